// File: rtl/pipelined_logic_unit.sv
// Pipelined WIDTH-bit bitwise logic unit: eight ops, STAGES register stages, ripple-ready handshake.
// Latency STAGES cycles from acceptance; a stalled output back-pressures every upstream stage.
module pipelined_logic_unit #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             zero,
  output logic             busy
);

  logic [STAGES-1:0]            v_q;
  logic [STAGES-1:0][WIDTH-1:0] res_q;
  logic [STAGES-1:0]            zero_q;
  logic [STAGES-1:0]            stage_ld;
  logic [WIDTH-1:0]             res_d;

  always_comb begin
    res_d = '0;
    case (op)
      3'b000:  res_d = A & B;
      3'b001:  res_d = A | B;
      3'b010:  res_d = ~(A | B);
      3'b011:  res_d = A ^ B;
      3'b100:  res_d = ~(A & B);
      3'b101:  res_d = ~(A ^ B);
      3'b110:  res_d = ~A;
      default: res_d = A;
    endcase
  end

  // Stage k can load iff out_ready or any stage from k to the last is empty.
  always_comb begin
    logic acc;
    acc      = out_ready;
    stage_ld = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc         = acc | ~v_q[k];
      stage_ld[k] = acc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q    <= '0;
      res_q  <= '0;
      zero_q <= '0;
    end else begin
      if (stage_ld[0]) begin
        v_q[0] <= in_valid;
        if (in_valid) begin
          res_q[0]  <= res_d;
          zero_q[0] <= ~|res_d;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (stage_ld[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) begin
            res_q[k]  <= res_q[k-1];
            zero_q[k] <= zero_q[k-1];
          end
        end
      end
    end
  end

  assign in_ready  = stage_ld[0];
  assign out_valid = v_q[STAGES-1];
  assign Out       = res_q[STAGES-1];
  assign zero      = zero_q[STAGES-1];
  assign busy      = |v_q;

endmodule

// File: tb/tb_pipelined_logic_unit.sv
// Directed bench for pipelined_logic_unit: default 32-bit/2-stage unit plus a 1-bit/1-stage corner instance.
module tb_pipelined_logic_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [2:0]  op;
  logic [31:0] A, B, Out;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, zero1, busy1;
  logic [2:0]  op1;
  logic [0:0]  A1, B1, Out1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_logic_unit #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .Out(Out),
    .zero(zero), .busy(busy)
  );

  pipelined_logic_unit #(.WIDTH(1), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1), .op(op1),
    .A(A1), .B(B1), .out_valid(out_valid1), .out_ready(out_ready1), .Out(Out1),
    .zero(zero1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sweep_exp [8];

  initial begin
    sweep_exp[0] = 32'h00F0_1234; sweep_exp[1] = 32'hFFF0_FFFF;
    sweep_exp[2] = 32'h000F_0000; sweep_exp[3] = 32'hFF00_EDCB;
    sweep_exp[4] = 32'hFF0F_EDCB; sweep_exp[5] = 32'h00FF_1234;
    sweep_exp[6] = 32'h0F0F_EDCB; sweep_exp[7] = 32'hF0F0_1234;

    reset = 1'b1; in_valid = 0; out_ready = 1; op = 0; A = 0; B = 0;
    in_valid1 = 0; out_ready1 = 1; op1 = 0; A1 = 0; B1 = 0;
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", Out, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    step();

    // Op sweep, back-to-back
    A = 32'hF0F0_1234; B = 32'h0FF0_FFFF; in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      op = i[2:0];
      step();
      if (i == 0) chk("sweep_lat", {31'd0, out_valid}, 32'd0);
      else begin
        chk("sweep_vld", {31'd0, out_valid}, 32'd1);
        chk($sformatf("sweep_op%0d", i - 1), Out, sweep_exp[i-1]);
      end
    end
    in_valid = 0;
    step();
    chk("sweep_vld7", {31'd0, out_valid}, 32'd1);
    chk("sweep_op7", Out, sweep_exp[7]);
    step();
    chk("sweep_drained", {31'd0, busy}, 32'd0);

    // Zero flag
    in_valid = 1; op = 3'b011; A = 32'hDEAD_BEEF; B = 32'hDEAD_BEEF;
    step();
    op = 3'b010; A = 0; B = 0;
    step();
    in_valid = 0;
    chk("xor_out", Out, 32'd0);
    chk("xor_zero", {31'd0, zero}, 32'd1);
    step();
    chk("nor_out", Out, 32'hFFFF_FFFF);
    chk("nor_zero", {31'd0, zero}, 32'd0);
    step();

    // Back-pressure
    out_ready = 0; in_valid = 1; op = 3'b111; B = 32'hFFFF_FFFF;
    A = 32'h11;
    chk("bp_rdy0", {31'd0, in_ready}, 32'd1);
    step();
    A = 32'h22;
    chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
    step();
    A = 32'h33;
    chk("bp_full_rdy", {31'd0, in_ready}, 32'd0);
    chk("bp_out_a", Out, 32'h11);
    step();
    chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
    chk("bp_out_b", Out, 32'h11);
    chk("bp_hold_vld", {31'd0, out_valid}, 32'd1);
    step();
    chk("bp_out_c", Out, 32'h11);
    out_ready = 1;
    #1;
    chk("bp_release_rdy", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 0;
    chk("bp_drain2", Out, 32'h22);
    step();
    chk("bp_drain3", Out, 32'h33);
    chk("bp_drain3_vld", {31'd0, out_valid}, 32'd1);
    step();
    chk("bp_empty_vld", {31'd0, out_valid}, 32'd0);
    chk("bp_empty_busy", {31'd0, busy}, 32'd0);

    // Full pipeline with simultaneous in/out for 10 cycles
    out_ready = 0; in_valid = 1; op = 3'b111;
    A = 32'd100; step();
    A = 32'd101; step();
    chk("sim_full_rdy", {31'd0, in_ready}, 32'd0);
    out_ready = 1;
    for (int j = 0; j < 10; j++) begin
      A = 32'd102 + j;
      #1;
      chk($sformatf("sim_rdy%0d", j), {31'd0, in_ready}, 32'd1);
      chk($sformatf("sim_vld%0d", j), {31'd0, out_valid}, 32'd1);
      chk($sformatf("sim_out%0d", j), Out, 32'd100 + j);
      step();
    end
    in_valid = 0;
    chk("sim_tail0", Out, 32'd110);
    step();
    chk("sim_tail1", Out, 32'd111);
    step();
    chk("sim_empty", {31'd0, busy}, 32'd0);

    // Reset mid-stream with two ops in flight
    out_ready = 0; in_valid = 1; op = 3'b001; A = 32'h5; B = 32'hA;
    step(); step();
    in_valid = 0;
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out", Out, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
    step();
    reset = 1'b0; out_ready = 1;
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("mid_no_stale%0d", j), {31'd0, out_valid}, 32'd0);
    end

    // WIDTH=1, STAGES=1 corner
    in_valid1 = 1; op1 = 3'b100; A1 = 1'b1; B1 = 1'b1;
    step();
    op1 = 3'b000;
    chk("w1_nand_vld", {31'd0, out_valid1}, 32'd1);
    chk("w1_nand_out", {31'd0, Out1}, 32'd0);
    chk("w1_nand_zero", {31'd0, zero1}, 32'd1);
    step();
    in_valid1 = 0;
    chk("w1_and_out", {31'd0, Out1}, 32'd1);
    chk("w1_and_zero", {31'd0, zero1}, 32'd0);
    step();
    chk("w1_empty", {31'd0, out_valid1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_logic_unit.md
# pipelined_logic_unit

Parametrised, pipelined bitwise logic unit for the execute path of the pipelined CPU. It generalises the fixed-width NOR cells to WIDTH-bit operands, eight selectable logic operations, a configurable number of register stages, and a valid/ready handshake with full back-pressure. It sits between the operand-forwarding mux and the writeback stage, and replaces per-operation gate trees with one registered unit.

## Interface
- WIDTH, 32: operand and result width in bits; minimum 1.
- STAGES, 2: number of register stages from input acceptance to output; minimum 1.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all pipeline state immediately.
- in_valid  input  1  A, B and op are valid this cycle.
- in_ready  output  1  unit accepts an operation this cycle.
- op  input  3  operation select, encoding listed under Operation.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- out_valid  output  1  Out and zero hold a valid result.
- out_ready  input  1  downstream consumes the result this cycle.
- Out  output  WIDTH  result.
- zero  output  1  high when the result in Out is all zeros.
- busy  output  1  high when any stage holds a valid entry.

## Operation
- Op encoding:
  - 000 AND, 001 OR, 010 NOR, 011 XOR.
  - 100 NAND, 101 XNOR, 110 NOT A (B ignored), 111 PASS A (B ignored).
- The operation is evaluated combinationally on the inputs and captured into stage 0 together with zero = ~|result.
- Stages 1..STAGES-1 carry {valid, result, zero} unchanged.
- Each stage k holds v[k] plus its data. The last stage drives out_valid, Out and zero.
- Advance rule, evaluated from the last stage backward:
  - Last stage may load when !v[last] or out_ready.
  - Stage k may load when !v[k] or stage k+1 loads this cycle.
  - This is a ripple-ready pipeline with no bubbles retained under stall.
- in_ready = stage 0 may load.
- Transfer in happens when in_valid & in_ready. Transfer out happens when out_valid & out_ready.
- When a stage loads from an invalid predecessor, its valid bit clears. Its data may hold its old value but must not change Out while out_valid = 0 is being held by a stalled last stage.
- Data registers load only when their stage loads, so Out/zero remain stable while out_valid & !out_ready.
- busy = OR of all v[k].
- Width rules:
  - All ops are bitwise; no carry and no sign handling.
  - NOT A and PASS A ignore B entirely.
  - WIDTH = 1 is legal.

## Timing
- Reset values, asserted asynchronously, held until the first clock after reset deasserts:
  - all v[k] = 0 and all data = 0.
  - out_valid = 0, Out = 0, zero = 0, busy = 0.
  - in_ready = 1.
- Latency: an op accepted at edge n appears with out_valid = 1 after edge n+STAGES-1, i.e. it is visible in the cycle following the STAGES-th edge counted from the accepting edge inclusive.
  - STAGES = 1: result visible the cycle after acceptance.
- Throughput: one op per cycle while out_ready = 1.
- Full: with all STAGES entries valid and out_ready = 0, in_ready = 0. No input is lost and the pipeline holds.
- Simultaneous out_ready = 1 and in_valid = 1 when full: one result leaves, all stages shift, the new op enters, and in_ready stays 1 in the same cycle.
- in_valid with in_ready = 0: inputs are not captured. The source must hold them; the unit does not require it.
- Reset mid-operation: all in-flight entries are discarded immediately; nothing is produced after release.
- out_ready while out_valid = 0: no effect.

## Test plan
- Reset: assert reset mid-stream with 2 ops in flight -> out_valid = 0, Out = 0, busy = 0 immediately, in_ready = 1; no stale result after release.
- Op sweep, WIDTH = 32, STAGES = 2, out_ready = 1: A = 32'hF0F0_1234, B = 32'h0FF0_FFFF, op 0..7 on consecutive cycles -> results in order:
  - 32'h00F0_1234, 32'hFFF0_FFFF, 32'h000F_0000, 32'hFF00_EDCB;
  - 32'hFF0F_EDCB, 32'h00FF_1234, 32'h0F0F_EDCB, 32'hF0F0_1234;
  - each appears 2 cycles after issue, back-to-back.
- Zero flag: op XOR with A = B = 32'hDEAD_BEEF -> Out = 0, zero = 1; op NOR with A = B = 0 -> Out = 32'hFFFF_FFFF, zero = 0.
- Back-pressure: hold out_ready = 0 and issue 3 ops -> in_ready drops after 2 accepts, Out holds the first result unchanged. Raise out_ready -> results drain in order, one per cycle, and the third op is accepted the same cycle.
- Simultaneous: pipeline full, out_ready = 1 and in_valid = 1 every cycle for 10 cycles -> 10 in, 10 out, in_ready constantly 1.
- Parameter corners: WIDTH = 1, STAGES = 1, op NAND, A = 1, B = 1 -> Out = 0, zero = 1, one cycle after acceptance.
